// File: rtl/serial_reciprocal.sv
// Serial fixed-point reciprocal: loads a signed QINT.FRAC operand in chunks,
// computes 1/x by restoring division one bit per cycle, and streams the result out.
module serial_reciprocal #(
    parameter int INT_BITS  = 6,
    parameter int FRAC_BITS = 10,
    parameter int IN_W      = 4,
    parameter int OUT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             abs_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);
    localparam int W     = INT_BITS + FRAC_BITS;
    localparam int IN_N  = W / IN_W;
    localparam int OUT_N = W / OUT_W;
    localparam int QW    = 2 * FRAC_BITS + 1;
    localparam int IC_W  = $clog2(IN_N + 1);
    localparam int OC_W  = $clog2(OUT_N + 1);
    localparam int DC_W  = $clog2(QW + 1);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    if (W % IN_W != 0) begin : g_bad_in_w
        $error("serial_reciprocal: operand width must be a multiple of IN_W");
    end
    if (W % OUT_W != 0) begin : g_bad_out_w
        $error("serial_reciprocal: operand width must be a multiple of OUT_W");
    end

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_DIV  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IC_W-1:0]   in_cnt_q, in_cnt_d;
    logic [OC_W-1:0]   out_cnt_q, out_cnt_d;
    logic [DC_W-1:0]   div_cnt_q, div_cnt_d;
    logic [W-1:0]      operand_q, operand_d;
    logic              abs_q, abs_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [W-1:0]      rem_q, rem_d;
    logic [QW-1:0]     quo_q, quo_d;
    logic [W-1:0]      result_q, result_d;
    logic              sat_q, sat_d;

    logic [W:0]        rem_sh;
    logic              rem_ge;
    logic [QW+W-1:0]   quo_ext;
    logic              sat_now;
    logic              neg_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            div_cnt_q <= '0;
            operand_q <= '0;
            abs_q     <= 1'b0;
            mag_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            div_cnt_q <= div_cnt_d;
            operand_q <= operand_d;
            abs_q     <= abs_d;
            mag_q     <= mag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        div_cnt_d = div_cnt_q;
        operand_d = operand_q;
        abs_d     = abs_q;
        mag_d     = mag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        sat_d     = sat_q;

        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        // Dividend is 2^(2*FRAC_BITS): a single one in its MSB, fed in on the first step.
        rem_sh  = {rem_q, (div_cnt_q == '0)};
        rem_ge  = (rem_sh >= {1'b0, mag_q});
        quo_ext = '0;
        sat_now = 1'b0;
        neg_now = operand_q[W-1] && !abs_q;

        case (state_q)
            S_LOAD: begin
                if (in_cnt_q == IC_W'(IN_N)) begin
                    // Handoff cycle: latch |x| and clear the divider before DIV starts.
                    mag_d     = operand_q[W-1] ? W'(-operand_q) : operand_q;
                    rem_d     = '0;
                    quo_d     = '0;
                    div_cnt_d = '0;
                    in_cnt_d  = '0;
                    state_d   = S_DIV;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        operand_d = W'({operand_q, in_data});
                        in_cnt_d  = in_cnt_q + 1'b1;
                        if (in_cnt_q == '0) begin
                            abs_d = abs_mode;
                        end
                    end
                end
            end

            S_DIV: begin
                busy      = 1'b1;
                rem_d     = rem_ge ? W'(rem_sh - {1'b0, mag_q}) : rem_sh[W-1:0];
                quo_d     = {quo_q[QW-2:0], rem_ge};
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DC_W'(QW - 1)) begin
                    quo_ext   = {{W{1'b0}}, quo_d};
                    sat_now   = (operand_q == '0) || (quo_ext > {{QW{1'b0}}, MAX_POS});
                    sat_d     = sat_now;
                    if (sat_now) begin
                        result_d = neg_now ? MIN_NEG : MAX_POS;
                    end else begin
                        result_d = neg_now ? W'(-quo_ext[W-1:0]) : quo_ext[W-1:0];
                    end
                    out_cnt_d = '0;
                    state_d   = S_OUT;
                end
            end

            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    result_d  = W'({result_q, {OUT_W{1'b0}}});
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == OC_W'(OUT_N - 1)) begin
                        out_cnt_d = '0;
                        sat_d     = 1'b0;
                        result_d  = '0;
                        state_d   = S_LOAD;
                    end
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase

        out_data = out_valid ? result_q[W-1 -: OUT_W] : '0;
        out_sat  = out_valid && sat_q;
    end

endmodule

// File: tb/tb_serial_reciprocal.sv
// Directed bench for serial_reciprocal: hand-computed reciprocals, stall runs,
// and reset in each phase.
module tb_serial_reciprocal;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       abs_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_sat;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    serial_reciprocal dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abs_mode  (abs_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    // Sends the first n chunks of x, MSB-first.
    task automatic send(input logic [15:0] x, input logic a, input bit gaps, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                abs_mode = ~a;
                repeat ($urandom_range(0, 3)) tick();
            end
            in_valid = 1'b1;
            in_data  = x[15 - 4*i -: 4];
            abs_mode = (i == 0) ? a : ~a;
            guard = 0;
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) check("in_ready_timeout", 32'd0, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        abs_mode = 1'b0;
    endtask

    task automatic wait_out(input bit check_lat);
        int n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
            if (check_lat && n == 5) begin
                check("div_in_ready", 32'(in_ready), 32'd0);
                check("div_busy", 32'(busy), 32'd1);
            end
        end
        if (n >= 200) check("out_valid_timeout", 32'd0, 32'd1);
        else if (check_lat) check("latency", 32'(n), 32'd22);
    endtask

    task automatic receive(input string tag, input logic [15:0] exp, input logic sat, input bit stalls);
        logic [7:0] chunk;
        for (int j = 0; j < 2; j++) begin
            chunk = exp[15 - 8*j -: 8];
            if (stalls) begin
                out_ready = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                    check({tag, "_stall_data"}, 32'(out_data), 32'(chunk));
                    check({tag, "_stall_sat"}, 32'(out_sat), 32'(sat));
                    tick();
                end
            end
            out_ready = 1'b1;
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"}, 32'(out_data), 32'(chunk));
            check({tag, "_sat"}, 32'(out_sat), 32'(sat));
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_data"}, 32'(out_data), 32'd0);
        check({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    localparam int NV = 11;
    logic [15:0] v_x   [NV] = '{16'h0400, 16'h0200, 16'h0800, 16'h8000, 16'h8000, 16'hF800,
                                16'hF800, 16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF};
    logic        v_abs [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] v_exp [NV] = '{16'h0400, 16'h0800, 16'h0200, 16'hFFE0, 16'h0020, 16'hFE00,
                                16'h0200, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF};
    logic        v_sat [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        repeat (2) tick();
        do_reset();

        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NV; k++) begin
                send(v_x[k], v_abs[k], pass == 1, 4);
                wait_out(pass == 0);
                receive($sformatf("vec%0d_p%0d", k, pass), v_exp[k], v_sat[k], pass == 1);
            end
        end

        // Partial load discarded by reset.
        send(16'h1234, 1'b1, 1'b0, 2);
        do_reset();
        send(16'h0400, 1'b0, 1'b0, 4);
        wait_out(1'b1);
        receive("after_rst_load", 16'h0400, 1'b0, 1'b0);

        // Reset in the middle of the division.
        send(16'h0200, 1'b0, 1'b0, 4);
        repeat (8) tick();
        do_reset();
        send(16'h0400, 1'b0, 1'b0, 4);
        wait_out(1'b1);
        receive("after_rst_div", 16'h0400, 1'b0, 1'b0);

        // Reset after the first output chunk has been taken.
        send(16'h0000, 1'b0, 1'b0, 4);
        wait_out(1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        do_reset();
        send(16'h0400, 1'b0, 1'b0, 4);
        wait_out(1'b1);
        receive("after_rst_out", 16'h0400, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
